// File: rtl/step_counter_pkg.sv
// Shared constants and helpers for the step counter and its prescaler.
package step_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Ceiling log2, usable in parameter context.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Prescaler: counts enabled cycles 0..PRESCALE-1 and strobes tick on the last one.
module step_prescaler
  import step_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sclr,
  output logic tick
);

  localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;
  logic          at_last;

  assign at_last = (pre_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (sclr) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= at_last ? '0 : pre_cnt + PW'(1);
    end
  end

  // rst gating keeps tick quiet during reset even when PRESCALE is 1.
  assign tick = en & ~sclr & ~rst & at_last;

endmodule

// File: rtl/step_counter_n.sv
// Modulo-N up/down counter with prescaler, wrap/saturate mode and terminal-count pulse.
// Optional STEP_COUNTER_N_GRAY_EN adds a registered Gray-coded copy of the count (out_gray).
module step_counter_n
  import step_counter_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int MODULUS  = 4,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             tc
`ifdef STEP_COUNTER_N_GRAY_EN
  ,
  output logic [WIDTH-1:0] out_gray
`endif
);

  localparam logic [WIDTH-1:0] MAXV   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] PENULT = WIDTH'(MODULUS - 2);
  localparam logic             SAT    = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] d_out;
  logic             d_tc;

  step_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .sclr (clr | load),
    .tick (tick)
  );

  // Next count and tc, priority clr > load > step; out-of-range states fall to 0.
  always_comb begin
    d_out = out;
    d_tc  = 1'b0;
    if (clr) begin
      d_out = '0;
    end else if (load) begin
      d_out = (load_val > MAXV) ? MAXV : load_val;
    end else if (tick) begin
      if (out > MAXV) begin
        d_out = '0;
      end else if (up == DIR_UP) begin
        if (out != MAXV) begin
          d_out = out + WIDTH'(1);
          d_tc  = SAT && (out == PENULT);
        end else if (!SAT) begin
          d_out = '0;
          d_tc  = 1'b1;
        end
      end else begin
        if (out != '0) begin
          d_out = out - WIDTH'(1);
          d_tc  = SAT && (out == WIDTH'(1));
        end else if (!SAT) begin
          d_out = MAXV;
          d_tc  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
      tc  <= 1'b0;
    end else begin
      out <= d_out;
      tc  <= d_tc;
    end
  end

`ifdef STEP_COUNTER_N_GRAY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_gray <= '0;
    else     out_gray <= d_out ^ (d_out >> 1);
  end
`endif

endmodule

// File: tb/tb_step_counter_n.sv
// Directed bench for step_counter_n across four parameter sets sharing one stimulus bus.
module tb_step_counter_n;

  logic       clk = 1'b0;
  logic       rst, en, up, clr, load;
  logic [3:0] load_val;

  logic [1:0] def_out;  logic def_tick, def_tc;
  logic [3:0] m10_out;  logic m10_tick, m10_tc;
  logic [3:0] sat_out;  logic sat_tick, sat_tc;
  logic [2:0] w3_out;   logic w3_tick, w3_tc;
`ifdef STEP_COUNTER_N_GRAY_EN
  logic [1:0] def_gray;
  logic [3:0] m10_gray, sat_gray;
  logic [2:0] w3_gray;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  step_counter_n #(.WIDTH(2), .MODULUS(4), .PRESCALE(1), .SATURATE(0)) u_def (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val[1:0]), .out(def_out), .tick(def_tick), .tc(def_tc)
`ifdef STEP_COUNTER_N_GRAY_EN
    , .out_gray(def_gray)
`endif
  );

  step_counter_n #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) u_m10 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .out(m10_out), .tick(m10_tick), .tc(m10_tc)
`ifdef STEP_COUNTER_N_GRAY_EN
    , .out_gray(m10_gray)
`endif
  );

  step_counter_n #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .out(sat_out), .tick(sat_tick), .tc(sat_tc)
`ifdef STEP_COUNTER_N_GRAY_EN
    , .out_gray(sat_gray)
`endif
  );

  step_counter_n #(.WIDTH(3), .MODULUS(8), .PRESCALE(1), .SATURATE(0)) u_w3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val[2:0]), .out(w3_out), .tick(w3_tick), .tc(w3_tc)
`ifdef STEP_COUNTER_N_GRAY_EN
    , .out_gray(w3_gray)
`endif
  );

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    rst = 1'b1;
    edge1();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    #2;
    vectors++;
    if (def_out !== 2'd0 || def_tc !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_tc: got out=%0d tc=%b want out=0 tc=0", def_out, def_tc);
    end
    vectors++;
    if (def_tick !== 1'b0) begin
      miscompares++; $display("FAIL reset_tick: got %b want 0", def_tick);
    end
    edge1();
    vectors++;
    if (m10_out !== 4'd0 || m10_tc !== 1'b0 || sat_out !== 4'd0) begin
      miscompares++; $display("FAIL reset_held: got m10=%0d tc=%b sat=%0d want 0 0 0", m10_out, m10_tc, sat_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_wrap_default();
    int e;
    apply_reset();
    en = 1'b1; up = 1'b1;
    #1;
    for (int k = 1; k <= 8; k++) begin
      edge1();
      e = k % 4;
      vectors++;
      if (def_out !== 2'(e) || def_tc !== (e == 0)) begin
        miscompares++;
        $display("FAIL def_wrap[%0d]: got out=%0d tc=%b want out=%0d tc=%b", k, def_out, def_tc, e, (e == 0));
      end
    end
  endtask

  task automatic test_prescale();
    int e;
    apply_reset();
    en = 1'b1; up = 1'b1;
    #1;
    for (int k = 1; k <= 30; k++) begin
      vectors++;
      if (m10_tick !== (((k - 1) % 3) == 2)) begin
        miscompares++; $display("FAIL pre_tick[%0d]: got %b want %b", k, m10_tick, (((k - 1) % 3) == 2));
      end
      edge1();
      e = (k / 3) % 10;
      vectors++;
      if (m10_out !== 4'(e) || m10_tc !== (k == 30)) begin
        miscompares++;
        $display("FAIL pre_out[%0d]: got out=%0d tc=%b want out=%0d tc=%b", k, m10_out, m10_tc, e, (k == 30));
      end
    end
    edge1();
    en = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (m10_tick !== 1'b0) begin
        miscompares++; $display("FAIL freeze_tick[%0d]: got %b want 0", k, m10_tick);
      end
      edge1();
      vectors++;
      if (m10_out !== 4'd0) begin
        miscompares++; $display("FAIL freeze_out[%0d]: got %0d want 0", k, m10_out);
      end
    end
    en = 1'b1;
    #1;
    vectors++;
    if (m10_tick !== 1'b0) begin
      miscompares++; $display("FAIL resume_tick0: got %b want 0", m10_tick);
    end
    edge1();
    vectors++;
    if (m10_tick !== 1'b1 || m10_out !== 4'd0) begin
      miscompares++; $display("FAIL resume_tick1: got tick=%b out=%0d want tick=1 out=0", m10_tick, m10_out);
    end
    edge1();
    vectors++;
    if (m10_out !== 4'd1) begin
      miscompares++; $display("FAIL resume_step: got %0d want 1", m10_out);
    end
  endtask

  task automatic test_saturate();
    int exp_o[4] = '{1, 0, 0, 0};
    logic exp_t[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    en = 1'b1; load = 1'b1; load_val = 4'd2;
    #1;
    vectors++;
    if (sat_tick !== 1'b0) begin
      miscompares++; $display("FAIL sat_load_tick: got %b want 0", sat_tick);
    end
    edge1();
    vectors++;
    if (sat_out !== 4'd2 || sat_tc !== 1'b0) begin
      miscompares++; $display("FAIL sat_load2: got out=%0d tc=%b want out=2 tc=0", sat_out, sat_tc);
    end
    load = 1'b0; up = 1'b0;
    for (int k = 0; k < 4; k++) begin
      edge1();
      vectors++;
      if (sat_out !== 4'(exp_o[k]) || sat_tc !== exp_t[k]) begin
        miscompares++;
        $display("FAIL sat_down[%0d]: got out=%0d tc=%b want out=%0d tc=%b", k, sat_out, sat_tc, exp_o[k], exp_t[k]);
      end
    end
    load = 1'b1; load_val = 4'd15;
    edge1();
    vectors++;
    if (sat_out !== 4'd9 || sat_tc !== 1'b0) begin
      miscompares++; $display("FAIL sat_load15: got out=%0d tc=%b want out=9 tc=0", sat_out, sat_tc);
    end
    load = 1'b0; up = 1'b1;
    edge1();
    vectors++;
    if (sat_out !== 4'd9 || sat_tc !== 1'b0) begin
      miscompares++; $display("FAIL sat_hold_top: got out=%0d tc=%b want out=9 tc=0", sat_out, sat_tc);
    end
    up = 1'b0;
    edge1();
    up = 1'b1;
    edge1();
    vectors++;
    if (sat_out !== 4'd9 || sat_tc !== 1'b1) begin
      miscompares++; $display("FAIL sat_land_top: got out=%0d tc=%b want out=9 tc=1", sat_out, sat_tc);
    end
  endtask

  task automatic test_full_range_down();
    apply_reset();
    en = 1'b1; up = 1'b0;
    edge1();
    vectors++;
    if (w3_out !== 3'd7 || w3_tc !== 1'b1) begin
      miscompares++; $display("FAIL w3_down_wrap: got out=%0d tc=%b want out=7 tc=1", w3_out, w3_tc);
    end
    edge1();
    vectors++;
    if (w3_out !== 3'd6 || w3_tc !== 1'b0) begin
      miscompares++; $display("FAIL w3_down: got out=%0d tc=%b want out=6 tc=0", w3_out, w3_tc);
    end
    up = 1'b1;
    edge1();
    edge1();
    vectors++;
    if (w3_out !== 3'd0 || w3_tc !== 1'b1) begin
      miscompares++; $display("FAIL w3_up_wrap: got out=%0d tc=%b want out=0 tc=1", w3_out, w3_tc);
    end
  endtask

  task automatic test_clr_load_on_tick();
    apply_reset();
    load = 1'b1; load_val = 4'd5;
    edge1();
    vectors++;
    if (m10_out !== 4'd5) begin
      miscompares++; $display("FAIL cl_load5: got %0d want 5", m10_out);
    end
    load = 1'b0; en = 1'b1; up = 1'b1;
    edge1();
    edge1();
    vectors++;
    if (m10_tick !== 1'b1) begin
      miscompares++; $display("FAIL cl_tick_ready: got %b want 1", m10_tick);
    end
    clr = 1'b1; load = 1'b1; load_val = 4'd7;
    #1;
    vectors++;
    if (m10_tick !== 1'b0) begin
      miscompares++; $display("FAIL cl_tick_masked: got %b want 0", m10_tick);
    end
    edge1();
    vectors++;
    if (m10_out !== 4'd0 || m10_tc !== 1'b0) begin
      miscompares++; $display("FAIL cl_clear: got out=%0d tc=%b want out=0 tc=0", m10_out, m10_tc);
    end
    clr = 1'b0; load = 1'b0;
    edge1();
    edge1();
    vectors++;
    if (m10_out !== 4'd0 || m10_tick !== 1'b1) begin
      miscompares++; $display("FAIL cl_restart_wait: got out=%0d tick=%b want out=0 tick=1", m10_out, m10_tick);
    end
    edge1();
    vectors++;
    if (m10_out !== 4'd1) begin
      miscompares++; $display("FAIL cl_restart_step: got %0d want 1", m10_out);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    load = 1'b1; load_val = 4'd7;
    edge1();
    load = 1'b0; en = 1'b1; up = 1'b1;
    edge1();
    vectors++;
    if (m10_out !== 4'd7) begin
      miscompares++; $display("FAIL ar_setup: got %0d want 7", m10_out);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (m10_out !== 4'd0 || m10_tc !== 1'b0 || m10_tick !== 1'b0 || def_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL ar_immediate: got out=%0d tc=%b tick=%b def_tick=%b want 0 0 0 0", m10_out, m10_tc, m10_tick, def_tick);
    end
    #1;
    rst = 1'b0;
    edge1();
    edge1();
    vectors++;
    if (m10_out !== 4'd0) begin
      miscompares++; $display("FAIL ar_phase: got %0d want 0 (prescaler not cleared)", m10_out);
    end
    edge1();
    vectors++;
    if (m10_out !== 4'd1) begin
      miscompares++; $display("FAIL ar_restart: got %0d want 1", m10_out);
    end
  endtask

`ifdef STEP_COUNTER_N_GRAY_EN
  task automatic test_gray();
    logic [2:0] g [8] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
    logic [2:0] prev;
    apply_reset();
    vectors++;
    if (w3_gray !== 3'd0) begin
      miscompares++; $display("FAIL gray_reset: got %0d want 0", w3_gray);
    end
    prev = 3'd0;
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 8; k++) begin
      edge1();
      vectors++;
      if (w3_gray !== g[k] || $countones(w3_gray ^ prev) != 1) begin
        miscompares++; $display("FAIL gray[%0d]: got %0d want %0d (prev %0d)", k, w3_gray, g[k], prev);
      end
      prev = w3_gray;
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_wrap_default();
    test_prescale();
    test_saturate();
    test_full_range_down();
    test_clr_load_on_tick();
    test_async_reset();
`ifdef STEP_COUNTER_N_GRAY_EN
    test_gray();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/step_counter_n.md
Name: step_counter_n

Overview:
- Parametrised modulo-N up/down counter with a built-in prescaler, so the count can step slowly through N states.
- Successor to the team's fixed 2-bit free-running state counter. Adds configurable width and modulus, enable, direction, synchronous clear and load, wrap or saturate mode, and a terminal-count strobe.
- Sits in the switch-cleanup path: it sequences scan and sample states and paces debounce windows.

Parameters:
- WIDTH, 2, count register width; WIDTH >= 1.
- MODULUS, 4, number of states (count range 0..MODULUS-1); 2 <= MODULUS <= 2**WIDTH.
- PRESCALE, 1, clock cycles per step; 1 means one step per enabled cycle; PRESCALE >= 1.
- SATURATE, 0, 0 = wrap at the ends of the range; 1 = hold at the ends.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  advance enable; low freezes the prescaler and the count.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear of the count and prescaler.
- load  in  1  synchronous load.
- load_val  in  WIDTH  value to load.
- out  out  WIDTH  registered count.
- tick  out  1  combinational step strobe.
- tc  out  1  registered terminal-count pulse.

Behaviour:
- Reset (asynchronous, any time, including mid-prescale):
  - out=0, internal prescaler pre_cnt=0, tc=0.
  - tick=0 while rst is high.
- Priority on each rising edge: rst > clr > load > step.
- clr: out<=0, pre_cnt<=0, tc<=0.
- load: out<=min(load_val, MODULUS-1); pre_cnt<=0; tc<=0.
- Prescaler:
  - pre_cnt has width max(1, clog2(PRESCALE)).
  - When en=1 it counts 0..PRESCALE-1 and then wraps.
  - It holds its value when en=0.
  - tick = en & ~clr & ~load & (pre_cnt==PRESCALE-1).
  - With PRESCALE=1, tick = en & ~clr & ~load.
- Step (edge where tick=1), up=1:
  - out<MODULUS-1: out<=out+1.
  - out==MODULUS-1, SATURATE=0: out<=0.
  - out==MODULUS-1, SATURATE=1: out holds.
- Step, up=0:
  - out>0: out<=out-1.
  - out==0, SATURATE=0: out<=MODULUS-1.
  - out==0, SATURATE=1: out holds.
- Latency: out changes on the same edge on which tick is sampled high. The first step after reset occurs PRESCALE enabled cycles later.
- tc is high for exactly one cycle, registered alongside out:
  - SATURATE=0: set on the step that wraps (out becomes 0 going up, or MODULUS-1 going down).
  - SATURATE=1: set on the step that lands on the limit (MODULUS-1 going up, 0 going down).
  - SATURATE=1: not reasserted while the count is held at the limit.
  - All other edges: tc<=0.
- Direction may change on any cycle; it takes effect on the next step. The prescaler phase is not disturbed.
- MODULUS == 2**WIDTH: wrap uses the same compare as any other modulus; no reliance on natural overflow.
- Out-of-range states (unreachable) map to 0 on the next step.

Optional Feature:
- Macro: STEP_COUNTER_N_GRAY_EN.
- Defined:
  - Adds output port out_gray (WIDTH bits), a registered Gray code of the next count: out_gray = out ^ (out>>1).
  - out_gray updates on the same edge as out.
  - out_gray resets to 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package step_counter_pkg:
  - DIR_UP=1'b1 and DIR_DOWN=1'b0.
  - MODE_WRAP=0 and MODE_SAT=1.
  - A clog2 constant function.
- Sub-module step_prescaler (param PRESCALE; ports clk, rst, en, sclr, tick):
  - Owns pre_cnt and tick generation.
  - sclr = clr | load.
- The top level holds the count, limit and tc logic.

Test Plan:
- Defaults (WIDTH=2, MODULUS=4, PRESCALE=1), en=1, up=1 for 8 cycles -> out 1,2,3,0,1,2,3,0; tc high only in cycles where out==0.
- WIDTH=4, MODULUS=10, PRESCALE=3, up=1 -> out increments every 3rd cycle, 0..9 then 0; tc high one cycle at the 9->0 wrap; en low for 5 cycles mid-prescale -> tick and out frozen, phase resumes.
- MODULUS=10, SATURATE=1, up=0 from load_val=2 -> out 1,0,0,0; tc pulses once on the 1->0 step; then load_val=15 -> out=9.
- load and clr in the same cycle as a tick with out=5 -> out=0, tc=0, next step after PRESCALE enabled cycles.
- rst pulsed asynchronously between edges while out=7 and pre_cnt=1 -> out, tc and pre_cnt read 0 immediately; counting restarts from 0 after rst falls.
- With STEP_COUNTER_N_GRAY_EN defined, count 0..7 (WIDTH=3, MODULUS=8) -> out_gray 0,1,3,2,6,7,5,4, with adjacent values differing in exactly one bit.
